// File: rtl/dcache_wb_ctrl_if.sv
// AXI write-channel bundle (AW, W, B) between the write-back controller and memory.
// The master side issues the address, data and response-ready signals.
interface dcache_wb_ctrl_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// D-cache victim write-back controller: buffers one dirty line, then writes it out
// as a single AXI INCR burst, with a hazard check against the buffered line.
module dcache_wb_ctrl #(
  parameter int LINE_WORDS  = 8,
  parameter int OFFSET_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_addr,
  input  logic [31:0]            in_wdata,
  input  logic [31:0]            chk_addr,
  output logic                   chk_hit,
  output logic                   busy,
  dcache_wb_ctrl_if.master       axi
);

  localparam int                CW        = $clog2(LINE_WORDS);
  localparam logic [CW-1:0]     LAST_IDX  = CW'(LINE_WORDS - 1);
  localparam logic [31:0]       LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [2:0] {IDLE, FILL, AW, W, B} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] index_reg;
  logic [31:0]   line_addr_reg;
  logic          in_ready_reg;
  logic          busy_reg;
  logic          awvalid_reg;
  logic          wvalid_reg;
  logic          wlast_reg;
  logic          bready_reg;
  logic [31:0]   wdata_reg;

  logic [31:0]   buf_mem [LINE_WORDS];
  logic          buf_we;
  logic [CW-1:0] buf_waddr;
  logic [CW-1:0] buf_raddr;
  logic [CW-1:0] index_next;

  assign index_next = index_reg + CW'(1);

  // Read address runs one beat ahead so the registered read lands on the cycle the beat is shown.
  always_comb begin
    buf_we    = in_valid & in_ready_reg;
    buf_waddr = count_reg;
    buf_raddr = index_reg;
    if (state_reg == AW) begin
      buf_raddr = '0;
    end else if (state_reg == W && axi.wready && index_reg != LAST_IDX) begin
      buf_raddr = index_next;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[buf_waddr] <= in_wdata;
    end
    wdata_reg <= buf_mem[buf_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      index_reg     <= '0;
      line_addr_reg <= '0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      wlast_reg     <= 1'b0;
      bready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            line_addr_reg <= in_addr & LINE_MASK;
            count_reg     <= CW'(1);
            busy_reg      <= 1'b1;
            state_reg     <= FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            if (count_reg == LAST_IDX) begin
              count_reg    <= '0;
              in_ready_reg <= 1'b0;
              awvalid_reg  <= 1'b1;
              state_reg    <= AW;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        AW: begin
          if (axi.awready) begin
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b1;
            index_reg   <= '0;
            wlast_reg   <= (LAST_IDX == '0);
            state_reg   <= W;
          end
        end
        W: begin
          if (axi.wready) begin
            if (index_reg == LAST_IDX) begin
              wvalid_reg <= 1'b0;
              wlast_reg  <= 1'b0;
              bready_reg <= 1'b1;
              index_reg  <= '0;
              state_reg  <= B;
            end else begin
              index_reg <= index_next;
              wlast_reg <= (index_next == LAST_IDX);
            end
          end
        end
        B: begin
          if (axi.bvalid) begin
            bready_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign busy        = busy_reg;
  assign chk_hit     = busy_reg & (((chk_addr ^ line_addr_reg) & LINE_MASK) == 32'd0);

  assign axi.awaddr  = line_addr_reg;
  assign axi.awlen   = 8'(LINE_WORDS - 1);
  assign axi.awsize  = 3'b010;
  assign axi.awvalid = awvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = 4'b1111;
  assign axi.wlast   = wlast_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.bready  = bready_reg;

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: random and directed line traffic with a random-readiness
// AXI slave, checked every cycle against a counting model of the write-back protocol.
module tb_dcache_wb_ctrl;
  localparam int LW = 8;
  localparam int NL = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] chk_addr;
  logic        chk_hit;
  logic        busy;

  dcache_wb_ctrl_if axi ();

  dcache_wb_ctrl #(.LINE_WORDS(LW), .OFFSET_BITS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_wdata (in_wdata),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .busy     (busy),
    .axi      (axi)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [31:0] la [NL];
  logic [31:0] lw [NL][LW];

  int          m_words = 0;
  int          m_beats = 0;
  bit          m_aw_done = 1'b0;
  int          cur_line = 0;
  logic [31:0] cur_addr = 32'd0;
  int          prod_line = 0;
  int          prod_word = 0;
  int          retired = 0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Cycle engine: producer, AXI slave and model until 'upto' lines have retired.
  task automatic run(input int upto, input int mode, input int gap_pct,
                     input int abort_beat, input bit check_lat);
    int budget = 0;
    int aw_wait = 0;
    bit tog = 1'b0;
    int t_first = 0;
    bit exp_inr, exp_busy, exp_awv, exp_wv, exp_br;
    bit hs_in, hs_aw, hs_w, hs_b;
    while (retired < upto) begin
      case (cyc % 3)
        0:       chk_addr = cur_addr + 32'($urandom_range(0, LW - 1)) * 32'd4;
        1:       chk_addr = cur_addr + 32'(LW * 4);
        default: chk_addr = $urandom;
      endcase
      #1;
      exp_inr  = (m_words < LW);
      exp_busy = (m_words > 0);
      exp_awv  = (m_words == LW) && !m_aw_done;
      exp_wv   = m_aw_done && (m_beats < LW);
      exp_br   = (m_beats == LW);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_inr});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("awvalid", {31'd0, axi.awvalid}, {31'd0, exp_awv});
      check("wvalid", {31'd0, axi.wvalid}, {31'd0, exp_wv});
      check("bready", {31'd0, axi.bready}, {31'd0, exp_br});
      check("chk_hit", {31'd0, chk_hit},
            {31'd0, exp_busy && ((chk_addr >> 5) == (cur_addr >> 5))});
      if (exp_awv) begin
        check("awaddr", axi.awaddr, cur_addr);
        check("awlen", {24'd0, axi.awlen}, 32'(LW - 1));
        check("awsize", {29'd0, axi.awsize}, 32'd2);
      end
      if (exp_wv) begin
        check("wdata", axi.wdata, lw[cur_line][m_beats]);
        check("wstrb", {28'd0, axi.wstrb}, 32'hF);
        check("wlast", {31'd0, axi.wlast}, {31'd0, m_beats == LW - 1});
      end

      if (prod_line < upto && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_wdata = lw[prod_line][prod_word];
        in_addr  = (prod_word == 0) ? la[prod_line] : $urandom;
      end else begin
        in_valid = 1'b0;
        in_wdata = $urandom;
        in_addr  = $urandom;
      end

      case (mode)
        0: begin
          axi.awready = 1'b1;
          axi.wready  = 1'b1;
          axi.bvalid  = 1'b1;
        end
        1: begin
          axi.awready = 1'($urandom_range(0, 1));
          axi.wready  = 1'($urandom_range(0, 1));
          axi.bvalid  = exp_br && 1'($urandom_range(0, 1));
        end
        default: begin
          if (exp_awv) begin
            axi.awready = (aw_wait >= 5);
            aw_wait++;
          end else begin
            axi.awready = 1'b0;
            aw_wait = 0;
          end
          axi.wready = tog;
          tog = !tog;
          axi.bvalid = exp_br;
        end
      endcase

      if (abort_beat >= 0 && m_aw_done && m_beats == abort_beat) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        m_words = 0;
        m_beats = 0;
        m_aw_done = 1'b0;
        retired++;
        chk_addr = cur_addr;
        #1;
        check("abort_wvalid", {31'd0, axi.wvalid}, 32'd0);
        check("abort_wlast", {31'd0, axi.wlast}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_chk_hit", {31'd0, chk_hit}, 32'd0);
        $display("line %0d addr=0x%08h aborted by reset at beat %0d", cur_line, cur_addr, abort_beat);
        return;
      end

      hs_in = in_valid && exp_inr;
      hs_aw = exp_awv && axi.awready;
      hs_w  = exp_wv && axi.wready;
      hs_b  = exp_br && axi.bvalid;
      @(posedge clk);
      cyc++;
      if (hs_in) begin
        if (m_words == 0) begin
          cur_line = prod_line;
          cur_addr = la[prod_line] & ~32'h1F;
          t_first  = cyc;
        end
        m_words++;
        prod_word++;
        if (prod_word == LW) begin
          prod_word = 0;
          prod_line++;
        end
      end
      if (hs_aw) m_aw_done = 1'b1;
      if (hs_w) m_beats++;
      if (hs_b) begin
        $display("line %0d addr=0x%08h written back, %0d beats", cur_line, cur_addr, LW);
        if (check_lat) check("latency", 32'(cyc - t_first), 32'(2 * LW + 1));
        m_words = 0;
        m_beats = 0;
        m_aw_done = 1'b0;
        retired++;
      end
      #1;
      budget++;
      if (budget > 3000) begin
        check("timeout", 32'(retired), 32'(upto));
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      la[i] = $urandom;
      for (int j = 0; j < LW; j++) lw[i][j] = $urandom;
    end
    la[0] = 32'h1FC0_0040;
    for (int j = 0; j < LW; j++) lw[0][j] = 32'hA0 + 32'(j);
    la[1] = 32'h0000_1234;
    la[3] = 32'h0000_2000;

    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_wdata = '0;
    chk_addr = '0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_chk_hit", {31'd0, chk_hit}, 32'd0);
    check("rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
    check("rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
    check("rst_wlast", {31'd0, axi.wlast}, 32'd0);
    check("rst_bready", {31'd0, axi.bready}, 32'd0);

    run(1, 0, 0, -1, 1'b1);    // back-to-back line, everything ready
    run(2, 1, 30, -1, 1'b0);   // unaligned first address, later addresses scrambled
    run(3, 2, 0, -1, 1'b0);    // awready stalled 5 cycles, wready toggling
    run(5, 1, 0, -1, 1'b0);    // in_valid held through AW/W/B, line at 0x2000
    run(6, 0, 0, 3, 1'b0);     // reset in W at beat 3
    run(7, 0, 0, -1, 1'b1);    // clean line after the abort
    for (int k = 8; k <= NL; k++) begin
      run(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 50)), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dcache_wb_ctrl.md
DCACHE_WB_CTRL -- requirements
Module: dcache_wb_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per cache line (power of 2, 2..16).
REQ-002 SHALL have parameter OFFSET_BITS, default 5, meaning byte-offset bits per line (log2(LINE_WORDS*4)).
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  d_cache presents one dirty-line word.
REQ-006 SHALL have port in_ready  out  1  controller accepts the word this cycle.
REQ-007 SHALL have port in_addr  in  32  line base address, sampled with the first accepted word only.
REQ-008 SHALL have port in_wdata  in  32  victim word, ascending word order.
REQ-009 SHALL have port chk_addr  in  32  d_cache read-miss address for hazard check.
REQ-010 SHALL have port chk_hit  out  1  chk_addr falls in the buffered, not yet retired line.
REQ-011 SHALL have port busy  out  1  a line is being filled or written back.
REQ-012 SHALL have ports awaddr out 32, awlen out 8, awsize out 3, awvalid out 1, awready in 1  AXI write address channel.
REQ-013 SHALL have ports wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1  AXI write data channel.
REQ-014 SHALL have ports bvalid in 1, bready out 1  AXI write response channel.

Function
REQ-015 SHALL implement states IDLE, FILL, AW, W, B; all handshakes complete when valid & ready are high on the same edge.
REQ-016 IDLE: in_ready=1; on in_valid SHALL store word 0 to buf[0], latch in_addr with low OFFSET_BITS forced to 0, set fill count to 1, go FILL.
REQ-017 FILL: in_ready=1; each accepted word SHALL be stored at buf[count], count+1; acceptance of word LINE_WORDS-1 SHALL go to AW; no in_valid holds state.
REQ-018 AW: awvalid=1, awaddr=latched line address, awlen=LINE_WORDS-1, awsize=3'b010 (constant); on awready SHALL go W with beat index 0.
REQ-019 W: wvalid=1, wdata=buf[index], wstrb=4'b1111, wlast=(index==LINE_WORDS-1); each wready SHALL advance index; wready on the last beat SHALL go B.
REQ-020 B: bready=1; on bvalid SHALL go IDLE; bresp is ignored.
REQ-021 in_ready SHALL be 0 in AW, W, B; a new line is accepted only in IDLE (one-line buffer, no overlap).
REQ-022 awvalid, wvalid, bready SHALL be 0 outside AW, W, B respectively; once raised, a valid SHALL stay high with stable payload until its handshake.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 chk_hit SHALL be combinational: busy & (chk_addr[31:OFFSET_BITS] == line_addr[31:OFFSET_BITS]); in FILL it compares the line being filled.
REQ-025 Registered count and index SHALL be log2(LINE_WORDS) bits wide and SHALL not wrap within a line.
REQ-026 The state SHALL return to IDLE on the edge bvalid is seen; chk_hit SHALL be 0 in the following cycle for that line.

Reset
REQ-027 On rst=1 at a clock edge, state SHALL become IDLE, count/index 0, line address 0, regardless of current state (mid-burst abort permitted).
REQ-028 After reset: in_ready=1, busy=0, chk_hit=0, awvalid=0, wvalid=0, wlast=0, bready=0; buffer contents need no reset.

Verification
REQ-029 Line 0x1FC0_0040, words 0xA0..0xA7 pushed back-to-back, awready/wready/bvalid tied 1 -> awaddr=0x1FC0_0040, awlen=7, 8 beats 0xA0..0xA7, wlast on beat 8 only, busy low 8+1+8+1 cycles after first push.
REQ-030 in_addr=0x0000_1234 on first word -> awaddr=0x0000_1220; in_addr changes on later words ignored.
REQ-031 awready held 0 for 5 cycles, wready toggling 1/0 -> awvalid/awaddr stable 5 cycles, wdata holds during wready=0, 8 beats in order, no lost or duplicate beat.
REQ-032 During W for line 0x0000_2000: chk_addr=0x0000_201C -> chk_hit=1; chk_addr=0x0000_2020 -> 0; after bvalid -> 0 for 0x0000_201C.
REQ-033 in_valid held 1 during AW/W/B -> in_ready=0, no buffer overwrite; second line accepted first cycle back in IDLE.
REQ-034 rst=1 in W at beat 3 -> next cycle IDLE, wvalid=0, busy=0, in_ready=1; new line then completes correctly.
